// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core: FSM state encodings, the RX FIFO
// entry layout and the parity function used by both directions.
package uart_pkg;

    localparam int DATA_BITS_BASE = 5;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

    // ptype=1 gives even parity (bit = XOR of data), ptype=0 gives odd.
    function automatic logic parity_calc(input logic [7:0] data, input logic [3:0] nbits,
                                         input logic ptype);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nbits)) acc ^= data[i];
        end
        return ptype ? acc : ~acc;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is accepted only
// when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_core.sv
// UART transceiver with baud tick generator, TX/RX framing FSMs, TX/RX FIFOs,
// sticky RX overrun and RTS flow control driven from RX FIFO occupancy.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DIV_W-1:0]                baud_div,
    input  logic [1:0]                      data_bit_num,
    input  logic                            stop_bit_num,
    input  logic                            parity_en,
    input  logic                            parity_type,
    input  logic [7:0]                      tx_wdata,
    input  logic                            tx_wvalid,
    output logic                            tx_wready,
    output logic [9:0]                      rx_rdata,
    output logic                            rx_rvalid,
    input  logic                            rx_rready,
    output logic [$clog2(TX_DEPTH+1)-1:0]   tx_level,
    output logic [$clog2(RX_DEPTH+1)-1:0]   rx_level,
    output logic                            rx_overrun,
    input  logic                            overrun_clr,
    output logic                            tx_busy,
    output logic                            tx,
    input  logic                            rx,
    input  logic                            cts_n,
    output logic                            rts_n
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

    // Tick generator; the divisor is only reloaded at wrap so a change never
    // produces a short period.
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            div_q   <= baud_div;
        end else if (div_cnt >= div_q) begin
            div_cnt <= '0;
            div_q   <= baud_div;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // TX FIFO
    logic       tx_push;
    logic       tx_pop;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;

    assign tx_wready = !tx_full;
    assign tx_push   = tx_wvalid && tx_wready;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    // TX FSM
    tx_state_t       tx_state;
    logic [OS_W-1:0] tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_data_q;
    logic [1:0]      tx_dbn_q;
    logic            tx_stop2_q;
    logic            tx_pen_q;
    logic            tx_ptype_q;
    logic            tx_stop_idx;
    logic            tx_q;
    logic            tx_frame_end;

    assign tx_frame_end = tick && (tx_cnt == OS_LAST) && (tx_state == TX_STOP) &&
                          (!tx_stop2_q || tx_stop_idx);
    // Popping at the final stop tick chains frames with no idle gap.
    assign tx_pop  = tick && !tx_empty && !cts_n && ((tx_state == TX_IDLE) || tx_frame_end);
    assign tx      = tx_q;
    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_data_q   <= '0;
            tx_dbn_q    <= '0;
            tx_stop2_q  <= 1'b0;
            tx_pen_q    <= 1'b0;
            tx_ptype_q  <= 1'b0;
            tx_stop_idx <= 1'b0;
            tx_q        <= 1'b1;
        end else if (tx_pop) begin
            tx_state   <= TX_START;
            tx_cnt     <= '0;
            tx_q       <= 1'b0;
            tx_data_q  <= tx_head;
            tx_dbn_q   <= data_bit_num;
            tx_stop2_q <= stop_bit_num;
            tx_pen_q   <= parity_en;
            tx_ptype_q <= parity_type;
        end else if (tick && tx_state != TX_IDLE) begin
            if (tx_cnt != OS_LAST) begin
                tx_cnt <= tx_cnt + 1'b1;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        tx_q     <= tx_data_q[0];
                    end
                    TX_DATA: begin
                        if (tx_bit == ({1'b0, tx_dbn_q} + 3'd4)) begin
                            tx_stop_idx <= 1'b0;
                            if (tx_pen_q) begin
                                tx_state <= TX_PARITY;
                                tx_q     <= parity_calc(tx_data_q, {2'b00, tx_dbn_q} + 4'(DATA_BITS_BASE),
                                                        tx_ptype_q);
                            end else begin
                                tx_state <= TX_STOP;
                                tx_q     <= 1'b1;
                            end
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_q   <= tx_data_q[tx_bit + 3'd1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state    <= TX_STOP;
                        tx_stop_idx <= 1'b0;
                        tx_q        <= 1'b1;
                    end
                    TX_STOP: begin
                        tx_q <= 1'b1;
                        if (tx_stop2_q && !tx_stop_idx) tx_stop_idx <= 1'b1;
                        else                            tx_state    <= TX_IDLE;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // RX synchroniser plus one extra stage for falling-edge detection
    logic rx_m;
    logic rx_s;
    logic rx_s_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    // RX FSM: start bit sampled at half period, later bits one full period apart.
    rx_state_t       rx_state;
    logic [OS_W-1:0] rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_data;
    logic [1:0]      rx_dbn_q;
    logic            rx_pen_q;
    logic            rx_ptype_q;
    logic            rx_perr;
    logic            rx_push;
    rx_entry_t       rx_push_data;
    logic            rx_samp;

    assign rx_samp = tick && (rx_cnt == ((rx_state == RX_START) ? OS_HALF : OS_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_data      <= '0;
            rx_dbn_q     <= '0;
            rx_pen_q     <= 1'b0;
            rx_ptype_q   <= 1'b0;
            rx_perr      <= 1'b0;
            rx_push      <= 1'b0;
            rx_push_data <= '0;
        end else begin
            rx_push <= 1'b0;
            if (rx_state == RX_IDLE) begin
                if (rx_s_d && !rx_s) begin
                    rx_state   <= RX_START;
                    rx_cnt     <= '0;
                    rx_data    <= '0;
                    rx_perr    <= 1'b0;
                    rx_dbn_q   <= data_bit_num;
                    rx_pen_q   <= parity_en;
                    rx_ptype_q <= parity_type;
                end
            end else if (rx_samp) begin
                rx_cnt <= '0;
                case (rx_state)
                    RX_START: begin
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end
                    RX_DATA: begin
                        rx_data[rx_bit] <= rx_s;
                        if (rx_bit == ({1'b0, rx_dbn_q} + 3'd4))
                            rx_state <= rx_pen_q ? RX_PARITY : RX_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end
                    RX_PARITY: begin
                        rx_perr  <= (rx_s != parity_calc(rx_data, {2'b00, rx_dbn_q} + 4'(DATA_BITS_BASE),
                                                         rx_ptype_q));
                        rx_state <= RX_STOP;
                    end
                    RX_STOP: begin
                        rx_push      <= 1'b1;
                        rx_push_data <= '{frame_err: !rx_s, parity_err: rx_perr, data: rx_data};
                        rx_state     <= RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end else if (tick) begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // RX FIFO, overrun and RTS
    logic rx_pop;
    logic rx_full;
    logic rx_empty;
    logic overrun_evt;

    assign rx_rvalid   = !rx_empty;
    assign rx_pop      = rx_rvalid && rx_rready;
    assign overrun_evt = rx_push && rx_full && !rx_pop;

    uart_sync_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_push_data),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun <= 1'b0;
            rts_n      <= 1'b0;
        end else begin
            if (overrun_evt)      rx_overrun <= 1'b1;
            else if (overrun_clr) rx_overrun <= 1'b0;
            rts_n <= (rx_level >= ($clog2(RX_DEPTH+1))'(RX_DEPTH - 1));
        end
    end

endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
Parametrised UART transceiver core with programmable baud divisor, 5–8 data bits, optional parity, 1/2 stop bits, and TX/RX FIFOs. It sits behind the register front-end and exchanges bytes over valid/ready streams instead of single-byte registers. It adds features the first-generation UART lacks:
- framing-error detection
- false-start rejection
- RX overrun flag
- FIFO-level-based RTS flow control

Parameters:
DIV_W, 16, width of baud_div
OVERSAMPLE, 16, sample ticks per bit (even, ≥4)
TX_DEPTH, 16, TX FIFO entries (power of 2)
RX_DEPTH, 16, RX FIFO entries (power of 2)

Ports:
clk  in  1  single clock; all logic posedge
reset  in  1  synchronous, active-high reset
baud_div  in  DIV_W  sample tick every baud_div+1 clk
data_bit_num  in  2  data bits = 5 + value
stop_bit_num  in  1  0: 1 stop bit; 1: 2 stop bits
parity_en  in  1  parity bit present
parity_type  in  1  1: even; 0: odd
tx_wdata  in  8  byte to send, LSB first
tx_wvalid  in  1  push request
tx_wready  out  1  = TX FIFO not full
rx_rdata  out  10  {frame_err, parity_err, data[7:0]}; unused high data bits are 0
rx_rvalid  out  1  = RX FIFO not empty
rx_rready  in  1  pop request
tx_level  out  $clog2(TX_DEPTH+1)  TX FIFO occupancy
rx_level  out  $clog2(RX_DEPTH+1)  RX FIFO occupancy
rx_overrun  out  1  sticky: frame dropped because RX FIFO was full
overrun_clr  in  1  clears rx_overrun
tx_busy  out  1  TX FSM not IDLE
tx  out  1  serial out
rx  in  1  serial in (asynchronous)
cts_n  in  1  low = peer may receive
rts_n  out  1  high = stop peer

Behaviour:
Reset (synchronous, active-high, takes effect on the next posedge):
- Output values: tx=1, tx_busy=0, tx_wready=1, rx_rvalid=0, levels=0, rx_overrun=0, rts_n=0.
- Both FIFOs are flushed; tick counter and both FSMs return to 0/IDLE.
- Reset mid-frame aborts the frame; tx is 1 the cycle after reset.

Tick generator:
- Counter runs 0..baud_div; tick is high for one clk when the counter is 0.
- A new baud_div takes effect at the next wrap.
- One bit period = OVERSAMPLE ticks.

Handshakes:
- Push happens when tx_wvalid & tx_wready.
- Pop happens when rx_rvalid & rx_rready.
- FIFOs are first-word-fall-through: data is visible the cycle after the push.
- rx_rdata is don't-care while rx_rvalid=0.

TX FSM (IDLE → START → DATA → [PARITY] → STOP → IDLE):
- Leaves IDLE on a tick when the FIFO is non-empty and cts_n=0; the head entry is popped and latched together with data_bit_num, stop_bit_num, parity_en and parity_type.
- Each state holds tx for exactly OVERSAMPLE ticks:
  - START: tx=0.
  - DATA: bits sent LSB first, count = 5 + data_bit_num.
  - PARITY: tx = parity_type ? ^data : ~^data, over the sent bits only.
  - STOP: 1 or 2 bit periods of tx=1.
- Back-to-back frames have no idle gap when the FIFO is non-empty.
- cts_n rising mid-frame does not interrupt the frame; it only blocks the next start.
- Config changes mid-frame do not affect the current frame.

RX path:
- rx passes through a 2-flop synchroniser (rx_s), reset value 1.
- IDLE: a falling edge of rx_s moves to START with the sample counter at 0.
- START: at OVERSAMPLE/2 ticks, rx_s=1 means false start → IDLE with no push. Otherwise the counter restarts and every later bit is sampled once at OVERSAMPLE ticks from the previous sample (mid-bit).
- DATA: sample 5 + data_bit_num bits.
- PARITY: if enabled, parity_err = received bit ≠ expected bit (same formula as TX).
- STOP: only the first stop bit is checked; frame_err = (sample == 0).
- After the stop sample, push {frame_err, parity_err, data} and return to IDLE immediately, so a 2-stop-bit sender does not desynchronise.
- Config is latched at the falling edge.

Overrun and flow control:
- If the RX FIFO is full at push time and no pop occurs in the same cycle, the frame is dropped, rx_overrun is set, and FIFO contents are unchanged.
- When full with a simultaneous pop, the push is accepted and the level stays equal.
- overrun_clr and a same-cycle overrun event together leave rx_overrun=1.
- rts_n = (rx_level ≥ RX_DEPTH−1), registered.

Decomposition:
Package uart_pkg:
- tx_state_t, rx_state_t enums
- DATA_BITS_BASE=5
- rx_entry_t struct {frame_err, parity_err, data}
- function parity_calc(data, nbits, type)

Sub-module uart_sync_fifo #(WIDTH, DEPTH):
- first-word-fall-through, full/empty/level outputs, simultaneous push+pop legal
- instantiated twice (TX 8-bit, RX 10-bit)

Test Plan:
1. baud_div=1, OVERSAMPLE=16, 8N1, push 0xA5 → tx low for 32 clk, then bits 1,0,1,0,0,1,0,1 at 32 clk each, then high; tx_busy high for exactly 320 clk.
2. Loopback tx→rx with 7E2 (data_bit_num=2, parity_en=1, parity_type=1, stop=1), push 0x55,0x2A,0x7F → rx_rdata = 0x055, 0x02A, 0x07F in order; rx_level reaches 3.
3. Drive an rx frame 0x3C (8O1) with the parity bit inverted and the stop bit at 0 → rx_rdata = 0x33C (frame_err=1, parity_err=1).
4. Send 17 frames with rx_rready=0 and RX_DEPTH=16 → rts_n=1 once the level reaches 15; the 17th frame is dropped; rx_overrun=1; the first popped entry is frame 1; overrun_clr → 0.
5. rx low for 4 ticks, then high → no push, rx_level stays 0; a valid frame immediately afterwards is received correctly.
6. cts_n=1, push 3 bytes → tx stays 1, tx_level=3; cts_n→0 → START within 1 bit period, then 3 back-to-back frames; cts_n=1 mid-frame 2 → frame 2 completes and frame 3 is held.
